sync_tx_scheduler: RTL
======================

# sync_tx_scheduler

Source-domain scheduler that shares one multi-bit data-synchronizer channel (bus plus enable, consumed in the destination domain by the `Data_SYNC` block) between several requesters. It arbitrates round-robin and presents one word with its source ID on the shared bus. It asserts the enable for a fixed number of cycles, then holds the bus stable for a fixed guard interval so the destination can safely capture it. It finally acknowledges the granted requester. The block lives entirely in the sending clock domain.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- BUS_WIDTH, 8, data word width
- ID_WIDTH, 2, source-ID width (≥ clog2(NUM_REQ))
- HOLD_CYCLES, 2, cycles `async_bus_en` stays high per transfer (≥1)
- GAP_CYCLES, 4, cycles bus stays stable with enable low after HOLD (≥1)

Ports:
- CLK  in  1  source-domain clock, all logic on rising edge
- RST  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester transfer request, level, held until `done`
- req_data  in  NUM_REQ*BUS_WIDTH  requester i's word at bits [i*BUS_WIDTH +: BUS_WIDTH]
- done  out  NUM_REQ  one-cycle acknowledge to the granted requester
- async_bus  out  BUS_WIDTH  word driven to the synchronizer
- async_src_id  out  ID_WIDTH  index of the requester owning `async_bus`
- async_bus_en  out  1  enable to the synchronizer
- busy  out  1  high in HOLD and GAP

## Operation
- Reset values (async, RST=0): state IDLE, `async_bus`=0, `async_src_id`=0, `async_bus_en`=0, `done`=0, `busy`=0, counter=0, rr pointer = NUM_REQ-1 (requester 0 has first priority).
- FSM states:
  - IDLE: if any `req` bit is set, pick the first set index scanning from pointer+1 upward, modulo NUM_REQ. Register `req_data` slice → `async_bus` and index → `async_src_id`. Set `async_bus_en`=1 and `busy`=1, update pointer to the winner, load counter, go to HOLD. If no request, stay in IDLE and keep all bus outputs unchanged.
  - HOLD: `async_bus_en`=1 for exactly HOLD_CYCLES cycles, then go to GAP.
  - GAP: `async_bus_en`=0, bus and ID unchanged, for exactly GAP_CYCLES cycles. `done[winner]`=1 only during the last GAP cycle. Then go to IDLE with `busy`=0.
- Data and ID are captured only at grant. Later changes to `req_data` do not affect the transfer in flight.
- `async_bus` and `async_src_id` never change outside the grant edge. After a transfer they keep their last values in IDLE.
- A requester deasserts `req` on the edge after it sees `done`. Because `done` occurs in the last GAP cycle, the following IDLE sees the updated `req`, so the same request cannot be granted twice.
- A `req` that drops before grant is withdrawn with no side effects. A `req` that drops during HOLD/GAP does not abort the transfer; `done` still pulses.
- Reset asserted mid-transfer: all outputs return immediately to reset values, the transfer is lost, and no `done` is issued.
- At most one `done` bit is high at a time. `done` is never high when `busy`=0.

## Timing
- Grant latency: `req` high at edge k in IDLE → `async_bus_en`=1 and bus valid from edge k (registered), visible in cycle k+1.
- Transfer occupancy: 1 IDLE cycle + HOLD_CYCLES + GAP_CYCLES. With the defaults that is 7 cycles per word.
- `done` is high in cycle HOLD_CYCLES+GAP_CYCLES after grant.
- Back-to-back: with a request pending, the next grant happens in the IDLE cycle right after GAP.
- Under continuous requests from all requesters, the grant order is 0,1,2,3,0,…
- Counter width: clog2(max(HOLD_CYCLES, GAP_CYCLES))+1. It counts down to 1, and the state change happens at count 1.

## Test plan
- Reset: hold RST=0 with `req`=4'hF → all outputs 0, no `done`. Release RST → first grant goes to requester 0.
- Single request: `req`=4'b0100 with data 8'hA5 →
  - `async_bus`=A5 and `async_src_id`=2.
  - `async_bus_en` high for exactly 2 cycles, then low for 4 with the bus stable.
  - `done`=4'b0100 in the 6th cycle after grant.
- Round-robin: all four requesting with data 11/22/33/44, each dropping `req` after its `done` →
  - Words appear in order 11,22,33,44, each 7 cycles apart.
  - Exactly one enable window per word.
- Fairness after a gap: after granting requester 1, raise `req`=4'b0011 → requester 0 is skipped? No: the scan starts at 2, so requester 0 is granted before requester 1.
- Data change and drop mid-transfer: change `req_data` and drop `req` during HOLD → bus keeps the captured value and `done` still pulses once.
- Reset mid-transfer: assert RST during GAP → bus, ID, enable and `busy` go to 0 at once, and no `done` is issued. After release, a pending request restarts cleanly from requester 0 priority.

Source files
------------

// File: rtl/sync_tx_scheduler.sv
// Round-robin scheduler that shares one bus+enable synchronizer channel between requesters.
// Each grant drives the enable for HOLD_CYCLES, then holds the bus for GAP_CYCLES, then acknowledges the winner.
module sync_tx_scheduler #(
   parameter int unsigned NUM_REQ     = 4,
   parameter int unsigned BUS_WIDTH   = 8,
   parameter int unsigned ID_WIDTH    = 2,
   parameter int unsigned HOLD_CYCLES = 2,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic                           CLK,
   input  logic                           RST,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ*BUS_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]             done,
   output logic [BUS_WIDTH-1:0]           async_bus,
   output logic [ID_WIDTH-1:0]            async_src_id,
   output logic                           async_bus_en,
   output logic                           busy
);

   localparam int unsigned MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(MAX_CYC) + 1;
   localparam int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HOLD = 2'd1,
      GAP  = 2'd2
   } state_e;

   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [ID_WIDTH-1:0]    ptr_q, ptr_d;
   logic [BUS_WIDTH-1:0]   bus_q, bus_d;
   logic [ID_WIDTH-1:0]    id_q, id_d;
   logic                   en_q, en_d;
   logic                   busy_q, busy_d;
   logic [NUM_REQ-1:0]     done_q, done_d;

   logic [BUS_WIDTH-1:0]   words [NUM_REQ];
   logic                   grant_found;
   logic [IDX_W-1:0]       grant_idx;
   logic [IDX_W-1:0]       scan_idx;

   // Unpack the flat request data into one word per requester.
   always_comb begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         words[i] = req_data[i*BUS_WIDTH +: BUS_WIDTH];
      end
   end

   // Round-robin scan starting one past the last winner.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         scan_idx = IDX_W'((32'(ptr_q) + off) % NUM_REQ);
         if (!grant_found && req[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ptr_q   <= ID_WIDTH'(NUM_REQ - 1);
         bus_q   <= '0;
         id_q    <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ptr_q   <= ptr_d;
         bus_q   <= bus_d;
         id_q    <= id_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next state; enable, busy and done are decoded from where we are heading so they stay registered.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      bus_d   = bus_q;
      id_d    = id_q;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = '0;

      case (state_q)
         IDLE: begin
            if (grant_found) begin
               state_d = HOLD;
               cnt_d   = CNT_W'(HOLD_CYCLES);
               ptr_d   = ID_WIDTH'(grant_idx);
               bus_d   = words[grant_idx];
               id_d    = ID_WIDTH'(grant_idx);
            end
         end
         HOLD: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = GAP;
               cnt_d   = CNT_W'(GAP_CYCLES);
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         GAP: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      en_d   = (state_d == HOLD);
      busy_d = (state_d != IDLE);
      if (state_d == GAP && cnt_d == CNT_W'(1)) begin
         done_d = NUM_REQ'(1) << id_d;
      end
   end

   assign done         = done_q;
   assign async_bus    = bus_q;
   assign async_src_id = id_q;
   assign async_bus_en = en_q;
   assign busy         = busy_q;

endmodule
